// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types, opcode/funct constants and ALU flag helper for the decode stage.
package decode_stage_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RW   = $clog2(NREG);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic add;
        logic sub;
        logic sll;
        logic slt;
        logic sltu;
        logic xor_;
        logic srl;
        logic sra;
        logic or_;
        logic and_;
        logic illegal;
    } control_info;

    typedef struct packed {
        control_info     ctr;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            rs1_rf;
        logic            rs2_rf;
    } dec_t;

    // alt selects sub over add and sra over srl
    function automatic control_info alu_flags(input logic [2:0] f3, input logic alt);
        control_info c;
        c = '0;
        case (f3)
            F3_ADD:  if (alt) c.sub = 1'b1; else c.add = 1'b1;
            F3_SLL:  c.sll  = 1'b1;
            F3_SLT:  c.slt  = 1'b1;
            F3_SLTU: c.sltu = 1'b1;
            F3_XOR:  c.xor_ = 1'b1;
            F3_SR:   if (alt) c.sra = 1'b1; else c.srl = 1'b1;
            F3_OR:   c.or_  = 1'b1;
            default: c.and_ = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile: 2R1W register file, x0 hardwired to zero, write-first read bypass.
module decode_stage_regfile
    import decode_stage_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [RW-1:0]   i_ra1,
    input  logic [RW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [RW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && i_wa != '0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : (i_we && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes RV32I ALU-class instructions, reads operands and hands a
// registered control/operand bundle to execute over a valid/ready handshake.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] INSTR,
    input  logic [XLEN-1:0] PC,
    input  logic            FLUSH,
    input  logic            WB_EN,
    input  logic [RW-1:0]   WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output control_info     CTR_INFO,
    output logic [XLEN-1:0] RS1_VAL,
    output logic [XLEN-1:0] RS2_VAL,
    output logic [RW-1:0]   RD,
    output logic            WB_REQ
);

    logic            r_valid;
    control_info     r_ctr;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [RW-1:0]   r_rd;
    logic            r_wb_req;
    logic [RW-1:0]   r_rs1_idx;
    logic [RW-1:0]   r_rs2_idx;
    logic            r_rs1_rf;
    logic            r_rs2_rf;

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    dec_t            w_dec;
    logic            w_accept;
    logic            w_wb_live;
    logic            w_upd1;
    logic            w_upd2;

    function automatic dec_t decode(input logic [XLEN-1:0] ins, pc, v1, v2);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shift;
        d     = '0;
        f3    = ins[14:12];
        f7    = ins[31:25];
        shift = f3 == F3_SLL || f3 == F3_SR;
        case (ins[6:0])
            OPC_OP: begin
                d.ctr         = alu_flags(f3, f7 == F7_ALT);
                d.ctr.illegal = !(f7 == '0 || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
                d.a           = v1;
                d.b           = v2;
                d.rs1_rf      = 1'b1;
                d.rs2_rf      = 1'b1;
            end
            OPC_OPIMM: begin
                // shifts take only shamt so the ALU never sees the funct7 bits
                d.ctr         = alu_flags(f3, shift && f7 == F7_ALT);
                d.ctr.illegal = shift && !(f7 == '0 || (f3 == F3_SR && f7 == F7_ALT));
                d.a           = v1;
                d.b           = shift ? {{(XLEN-5){1'b0}}, ins[24:20]} : {{(XLEN-12){ins[31]}}, ins[31:20]};
                d.rs1_rf      = 1'b1;
            end
            OPC_LUI: begin
                d.ctr.add = 1'b1;
                d.b       = {ins[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                d.ctr.add = 1'b1;
                d.a       = pc;
                d.b       = {ins[31:12], 12'b0};
            end
            default: d.ctr.illegal = 1'b1;
        endcase
        if (d.ctr.illegal) begin
            d             = '0;
            d.ctr.illegal = 1'b1;
        end
        return d;
    endfunction

    decode_stage_regfile u_rf (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_ra1   (INSTR[19:15]),
        .i_ra2   (INSTR[24:20]),
        .o_rd1   (w_rs1_data),
        .o_rd2   (w_rs2_data),
        .i_we    (WB_EN),
        .i_wa    (WB_RD),
        .i_wd    (WB_DATA)
    );

    assign w_dec     = decode(INSTR, PC, w_rs1_data, w_rs2_data);
    assign IN_READY  = !r_valid || OUT_READY;
    assign w_accept  = IN_VALID && IN_READY && !FLUSH;
    assign w_wb_live = WB_EN && WB_RD != '0 && r_valid;
    assign w_upd1    = w_wb_live && r_rs1_rf && WB_RD == r_rs1_idx;
    assign w_upd2    = w_wb_live && r_rs2_rf && WB_RD == r_rs2_idx;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid   <= 1'b0;
            r_ctr     <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_rd      <= '0;
            r_wb_req  <= 1'b0;
            r_rs1_idx <= '0;
            r_rs2_idx <= '0;
            r_rs1_rf  <= 1'b0;
            r_rs2_rf  <= 1'b0;
        end else if (FLUSH) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_ctr     <= w_dec.ctr;
            r_rs1_val <= w_dec.a;
            r_rs2_val <= w_dec.b;
            r_rd      <= INSTR[11:7];
            r_wb_req  <= !w_dec.ctr.illegal && INSTR[11:7] != '0;
            r_rs1_idx <= INSTR[19:15];
            r_rs2_idx <= INSTR[24:20];
            r_rs1_rf  <= w_dec.rs1_rf;
            r_rs2_rf  <= w_dec.rs2_rf;
        end else if (OUT_READY) begin
            r_valid <= 1'b0;
        end else begin
            if (w_upd1) r_rs1_val <= WB_DATA;
            if (w_upd2) r_rs2_val <= WB_DATA;
        end
    end

    assign OUT_VALID = r_valid;
    assign CTR_INFO  = r_ctr;
    assign RS1_VAL   = r_rs1_val;
    assign RS2_VAL   = r_rs2_val;
    assign RD        = r_rd;
    assign WB_REQ    = r_wb_req;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table, hand-written handshake sequences and
// randomized assembler-level stimulus against a register-array reference model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTR = '0;
    logic [31:0] PC = '0;
    logic        FLUSH = 1'b0;
    logic        WB_EN = 1'b0;
    logic [4:0]  WB_RD = '0;
    logic [31:0] WB_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    control_info CTR_INFO;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic [4:0]  RD;
    logic        WB_REQ;

    int total = 0;
    int bad = 0;
    logic [31:0] regs [32];

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        control_info ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wbq;
    } vec_t;

    vec_t vecs [12];

    decode_stage dut (
        .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .PC(PC), .FLUSH(FLUSH), .WB_EN(WB_EN), .WB_RD(WB_RD),
        .WB_DATA(WB_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .CTR_INFO(CTR_INFO), .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .RD(RD), .WB_REQ(WB_REQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and 10 illegal
    function automatic control_info ctr_of(input int k);
        control_info c;
        c = '0;
        case (k)
            0: c.add = 1'b1;
            1: c.sub = 1'b1;
            2: c.sll = 1'b1;
            3: c.slt = 1'b1;
            4: c.sltu = 1'b1;
            5: c.xor_ = 1'b1;
            6: c.srl = 1'b1;
            7: c.sra = 1'b1;
            8: c.or_ = 1'b1;
            9: c.and_ = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        WB_EN = 1'b1; WB_RD = rd; WB_DATA = d;
        tick();
        WB_EN = 1'b0;
        if (rd != 0) regs[rd] = d;
    endtask

    task automatic outs(input string nm, input control_info c, input logic [31:0] a, b,
                        input logic [4:0] rd, input logic wbq);
        chk({nm, ".valid"}, 32'(OUT_VALID), 32'd1);
        chk({nm, ".ctr"}, 32'(CTR_INFO), 32'(c));
        chk({nm, ".rs1"}, RS1_VAL, a);
        chk({nm, ".rs2"}, RS2_VAL, b);
        chk({nm, ".rd"}, 32'(RD), 32'(rd));
        chk({nm, ".wbreq"}, 32'(WB_REQ), 32'(wbq));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".valid"}, 32'(OUT_VALID), 32'd0);
        chk({nm, ".ctr"}, 32'(CTR_INFO), 32'd0);
        chk({nm, ".rs1"}, RS1_VAL, 32'd0);
        chk({nm, ".rs2"}, RS2_VAL, 32'd0);
        chk({nm, ".rd"}, 32'(RD), 32'd0);
        chk({nm, ".wbreq"}, 32'(WB_REQ), 32'd0);
    endtask

    function automatic logic [31:0] rv(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (WB_EN && WB_RD == idx) return WB_DATA;
        return regs[idx];
    endfunction

    initial begin
        int f3of [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        for (int i = 0; i < 32; i++) regs[i] = '0;
        #3 RSTN = 1'b0;
        #2;
        chk_zero("reset");
        chk("reset.in_ready", 32'(IN_READY), 32'd1);
        tick();
        RSTN = 1'b1;

        wb(5'd1, 32'd7);
        wb(5'd2, 32'd3);

        vecs[0]  = '{32'h00500093, 32'h0,   ctr_of(0),  32'd0,     32'd5,        5'd1, 1'b1};
        vecs[1]  = '{32'h402081B3, 32'h0,   ctr_of(1),  32'd7,     32'd3,        5'd3, 1'b1};
        vecs[2]  = '{32'h4030D293, 32'h0,   ctr_of(7),  32'd7,     32'd3,        5'd5, 1'b1};
        vecs[3]  = '{32'h00309293, 32'h0,   ctr_of(2),  32'd7,     32'd3,        5'd5, 1'b1};
        vecs[4]  = '{32'h0000007F, 32'h0,   ctr_of(10), 32'd0,     32'd0,        5'd0, 1'b0};
        vecs[5]  = '{32'h12345337, 32'h0,   ctr_of(0),  32'd0,     32'h12345000, 5'd6, 1'b1};
        vecs[6]  = '{32'hFFFFF397, 32'h100, ctr_of(0),  32'h100,   32'hFFFFF000, 5'd7, 1'b1};
        vecs[7]  = '{32'hFFF08413, 32'h0,   ctr_of(0),  32'd7,     32'hFFFFFFFF, 5'd8, 1'b1};
        vecs[8]  = '{32'h40209233, 32'h0,   ctr_of(10), 32'd0,     32'd0,        5'd4, 1'b0};
        vecs[9]  = '{32'h0020B233, 32'h0,   ctr_of(4),  32'd7,     32'd3,        5'd4, 1'b1};
        vecs[10] = '{32'h00208033, 32'h0,   ctr_of(0),  32'd7,     32'd3,        5'd0, 1'b0};
        vecs[11] = '{32'h40309293, 32'h0,   ctr_of(10), 32'd0,     32'd0,        5'd5, 1'b0};

        for (int i = 0; i < 12; i++) begin
            IN_VALID = 1'b1; INSTR = vecs[i].ins; PC = vecs[i].pc; OUT_READY = 1'b1;
            tick();
            IN_VALID = 1'b0;
            outs($sformatf("vec%0d", i), vecs[i].ctr, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wbq);
        end
        tick();
        chk("drain.valid", 32'(OUT_VALID), 32'd0);

        // stall with a write to the held rs1
        IN_VALID = 1'b1; INSTR = 32'h002081B3; OUT_READY = 1'b0;
        tick();
        INSTR = 32'h0020B233;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin WB_EN = 1'b1; WB_RD = 5'd1; WB_DATA = 32'd9; end
            tick();
            WB_EN = 1'b0;
            chk($sformatf("stall%0d.in_ready", c), 32'(IN_READY), 32'd0);
            outs($sformatf("stall%0d", c), ctr_of(0), (c == 0) ? 32'd7 : 32'd9, 32'd3, 5'd3, 1'b1);
        end
        regs[1] = 32'd9;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        chk("release.valid", 32'(OUT_VALID), 32'd0);

        // same-cycle bypass and x0
        IN_VALID = 1'b1; INSTR = 32'h002081B3; WB_EN = 1'b1; WB_RD = 5'd2; WB_DATA = 32'h55;
        tick();
        IN_VALID = 1'b0; WB_EN = 1'b0; regs[2] = 32'h55;
        outs("bypass", ctr_of(0), 32'd9, 32'h55, 5'd3, 1'b1);
        wb(5'd0, 32'hDEAD);
        IN_VALID = 1'b1; INSTR = 32'h000001B3;
        tick();
        IN_VALID = 1'b0;
        outs("x0", ctr_of(0), 32'd0, 32'd0, 5'd3, 1'b1);

        // flush a held entry and the incoming instruction
        IN_VALID = 1'b1; INSTR = 32'h002081B3; OUT_READY = 1'b0;
        tick();
        FLUSH = 1'b1; INSTR = 32'h0020B233;
        tick();
        chk("flush.valid", 32'(OUT_VALID), 32'd0);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        chk("flush.after", 32'(OUT_VALID), 32'd0);

        // asynchronous reset mid-stall
        IN_VALID = 1'b1; INSTR = 32'h002081B3; OUT_READY = 1'b0;
        tick();
        IN_VALID = 1'b0;
        RSTN = 1'b0;
        #1;
        chk_zero("rststall");
        tick();
        RSTN = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        OUT_READY = 1'b1; IN_VALID = 1'b1; INSTR = 32'h002081B3;
        tick();
        IN_VALID = 1'b0;
        outs("postrst", ctr_of(0), 32'd0, 32'd0, 5'd3, 1'b1);

        // randomized instructions with concurrent writeback
        for (int n = 0; n < 200; n++) begin
            int k, kind;
            logic [4:0] rs1, rs2, rd, sh;
            logic [2:0] f3;
            logic [11:0] imm;
            logic [31:0] r, ins, ea, eb, pc;
            logic [6:0] opc;
            r = $urandom();
            rs1 = r[4:0]; rs2 = r[9:5]; rd = r[14:10]; sh = r[19:15]; imm = r[31:20];
            pc = $urandom() & 32'hFFFFFFFC;
            WB_EN = 1'($urandom_range(0, 1)); WB_RD = 5'($urandom_range(0, 31)); WB_DATA = $urandom();
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                k = $urandom_range(0, 9);
                f3 = 3'(f3of[k]);
                ins = {(k == 1 || k == 7) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
                ea = rv(rs1); eb = rv(rs2);
            end else if (kind == 1) begin
                k = $urandom_range(0, 8);
                if (k != 0) k++;
                f3 = 3'(f3of[k]);
                if (k == 2 || k == 6 || k == 7) begin
                    imm = {(k == 7) ? 7'h20 : 7'h00, sh};
                    eb = {27'd0, sh};
                end else begin
                    eb = {{20{imm[11]}}, imm};
                end
                ins = {imm, rs1, f3, rd, 7'h13};
                ea = rv(rs1);
            end else if (kind == 2) begin
                k = 0;
                r = $urandom();
                ins = {r[31:12], rd, r[0] ? 7'h17 : 7'h37};
                ea = r[0] ? pc : 32'd0;
                eb = {r[31:12], 12'd0};
            end else begin
                k = 10;
                do opc = 7'($urandom()); while (opc == 7'h33 || opc == 7'h13 || opc == 7'h37 || opc == 7'h17);
                r = $urandom();
                ins = {r[31:7], opc};
                ea = 0; eb = 0;
            end
            IN_VALID = 1'b1; INSTR = ins; PC = pc; OUT_READY = 1'b1;
            tick();
            IN_VALID = 1'b0;
            if (WB_EN && WB_RD != 0) regs[WB_RD] = WB_DATA;
            WB_EN = 1'b0;
            outs($sformatf("rnd%0d", n), ctr_of(k), ea, eb, ins[11:7], k != 10 && ins[11:7] != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
